// File: rtl/arb_pkg.sv
// arb_pkg: shared state type and index helpers for the arb_rr arbiter.
package arb_pkg;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int oh2idx(input logic [63:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 64; i++)
            if (oh[i]) idx = idx | i;
        return idx;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational first-set-bit picker; MSB=1 favours the highest index.
module arb_pick #(
    parameter int N   = 4,
    parameter int MSB = 1
) (
    input  logic [N-1:0] i_vec,
    output logic [N-1:0] o_oh
);

    always_comb begin
        o_oh = '0;
        for (int i = 0; i < N; i++)
            if (i_vec[(MSB != 0) ? i : N-1-i]) o_oh = N'(1) << ((MSB != 0) ? i : N-1-i);
    end

endmodule

// File: rtl/arb_rr.sv
// arb_rr: registered N-way arbiter with round-robin or fixed priority and grant hold.
// Define ARB_WATCHDOG_EN to add the MAX_HOLD forced-release watchdog.
module arb_rr
    import arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int RR       = 1,
    parameter  int MSB      = 1,
    parameter  int MAX_HOLD = 16,
    localparam int IDXW     = idx_w(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            ack,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld,
    output logic            timeout
);

    state_t          r_state;
    logic [N-1:0]    r_gnt;
    logic [IDXW-1:0] r_idx;
    logic            r_vld;
    logic [N-1:0]    w_cand;
    logic [N-1:0]    w_win;
    logic [IDXW-1:0] w_widx;
    logic            w_busy;
    logic            w_rel;
    logic            w_go;
    logic            w_force;

    if (N < 2 || MAX_HOLD < 2) begin : g_param_chk
        $error("arb_rr: N and MAX_HOLD must both be at least 2");
    end

    assign w_busy = (r_state == BUSY);
    assign w_rel  = w_busy && (ack || !req[r_idx] || w_force);
    assign w_go   = !w_busy || w_rel;
    // the releasing holder sits out the re-arbitration of its own release cycle
    assign w_cand = w_busy ? (req & ~r_gnt) : req;
    assign w_widx = IDXW'(oh2idx(64'(w_win)));

    if (RR != 0) begin : g_rr
        logic [IDXW-1:0] r_ptr;
        logic [N-1:0]    w_mask;
        logic [N-1:0]    w_hi;
        logic [N-1:0]    w_any;
        // mask includes ptr itself: the previous holder is already excluded on a
        // BUSY handoff, and from reset this makes index ptr=0 the first choice
        always_comb begin
            w_mask = '0;
            for (int i = 0; i < N; i++)
                w_mask[i] = (MSB != 0) ? (i <= int'(r_ptr)) : (i >= int'(r_ptr));
        end
        arb_pick #(.N(N), .MSB(MSB)) u_pick_hi (.i_vec(w_cand & w_mask), .o_oh(w_hi));
        arb_pick #(.N(N), .MSB(MSB)) u_pick_all (.i_vec(w_cand), .o_oh(w_any));
        assign w_win = (|w_hi) ? w_hi : w_any;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)
                r_ptr <= '0;
            else if (w_go && |w_cand)
                r_ptr <= w_widx;
    end else begin : g_fixed
        arb_pick #(.N(N), .MSB(MSB)) u_pick_all (.i_vec(w_cand), .o_oh(w_win));
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_vld   <= 1'b0;
        end else if (w_go) begin
            r_state <= (|w_cand) ? BUSY : IDLE;
            r_gnt   <= w_win;
            r_idx   <= w_widx;
            r_vld   <= |w_cand;
        end

`ifdef ARB_WATCHDOG_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] r_cnt;
    logic          r_timeout;
    assign w_force = w_busy && !ack && req[r_idx] && (r_cnt == CW'(MAX_HOLD - 1));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
            r_cnt     <= w_go ? '0 : r_cnt + 1'b1;
        end
    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    assign gnt     = r_gnt;
    assign gnt_idx = r_idx;
    assign gnt_vld = r_vld;

endmodule

// File: tb/tb_arb_rr.sv
// tb_arb_rr: directed scoreboard bench for a round-robin (MSB=0) and a fixed-priority (MSB=1) arb_rr.
module tb_arb_rr;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_a = '0;
    logic [3:0] req_f = '0;
    logic       ack_a = 1'b0;
    logic       ack_f = 1'b0;
    logic [3:0] gnt_a, gnt_f;
    logic [1:0] idx_a, idx_f;
    logic       vld_a, vld_f, to_a, to_f;

    typedef struct packed {
        logic       sel;
        logic [3:0] gnt;
        logic       to;
    } exp_t;

    exp_t  q[$];
    string tq[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    arb_rr #(.N(4), .RR(1), .MSB(0), .MAX_HOLD(4)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req_a), .ack(ack_a),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a), .timeout(to_a)
    );

    arb_rr #(.N(4), .RR(0), .MSB(1), .MAX_HOLD(4)) u_fp (
        .clk(clk), .rst_n(rst_n), .req(req_f), .ack(ack_f),
        .gnt(gnt_f), .gnt_idx(idx_f), .gnt_vld(vld_f), .timeout(to_f)
    );

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic check1(input string tag, input string what, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s %s: observed %b expected %b", tag, what, obs, exp);
        end
    endtask

    task automatic chk();
        exp_t  e;
        string t;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = q.pop_front();
        t = tq.pop_front();
        check1(t, "gnt", e.sel ? gnt_f : gnt_a, e.gnt);
        check1(t, "gnt_idx", {2'b00, e.sel ? idx_f : idx_a}, {2'b00, idx_of(e.gnt)});
        check1(t, "gnt_vld", {3'b000, e.sel ? vld_f : vld_a}, {3'b000, |e.gnt});
        check1(t, "timeout", {3'b000, e.sel ? to_f : to_a}, {3'b000, e.to});
    endtask

    task automatic expect_now(input logic sel, input logic [3:0] eg, input logic et, input string tag);
        q.push_back('{sel: sel, gnt: eg, to: et});
        tq.push_back(tag);
    endtask

    task automatic cyc(input logic sel, input logic [3:0] r, input logic a,
                       input logic [3:0] eg, input logic et, input string tag);
        if (sel) begin
            req_f = r;
            ack_f = a;
        end else begin
            req_a = r;
            ack_a = a;
        end
        expect_now(sel, eg, et, tag);
        @(posedge clk);
        #1;
        chk();
    endtask

    initial begin
        #12;
        expect_now(0, 4'b0000, 0, "reset_rr");
        chk();
        expect_now(1, 4'b0000, 0, "reset_fp");
        chk();
        rst_n = 1'b1;

        cyc(0, 4'b1111, 0, 4'b0001, 0, "t1_first");
        cyc(0, 4'b1111, 1, 4'b0010, 0, "t1_rot1");
        cyc(0, 4'b1111, 1, 4'b0100, 0, "t1_rot2");
        cyc(0, 4'b1111, 1, 4'b1000, 0, "t1_rot3");
        cyc(0, 4'b1111, 1, 4'b0001, 0, "t1_wrap");

        cyc(0, 4'b1110, 0, 4'b0010, 0, "t3_drop_next");
        cyc(0, 4'b0000, 0, 4'b0000, 0, "t3_drop_idle");

        cyc(0, 4'b0010, 0, 4'b0010, 0, "t4_grant");
        cyc(0, 4'b0010, 1, 4'b0000, 0, "t4_bubble");
        cyc(0, 4'b0010, 0, 4'b0010, 0, "t4_regrant");
        cyc(0, 4'b0010, 0, 4'b0010, 0, "t4_hold");
        cyc(0, 4'b0000, 0, 4'b0000, 0, "t4_idle");

        cyc(0, 4'b0001, 0, 4'b0001, 0, "hold_grant");
        cyc(0, 4'b1111, 0, 4'b0001, 0, "hold_ign1");
        cyc(0, 4'b1111, 0, 4'b0001, 0, "hold_ign2");
        cyc(0, 4'b1111, 1, 4'b0010, 0, "hold_ack");

`ifdef ARB_WATCHDOG_EN
        cyc(0, 4'b0011, 0, 4'b0010, 0, "t5_busy2");
        cyc(0, 4'b0011, 0, 4'b0010, 0, "t5_busy3");
        cyc(0, 4'b0011, 0, 4'b0010, 0, "t5_busy4");
        cyc(0, 4'b0011, 0, 4'b0001, 1, "t5_forced");
        cyc(0, 4'b0011, 0, 4'b0001, 0, "t5_pulse_end");
`else
        for (int i = 0; i < 5; i++)
            cyc(0, 4'b0011, 0, 4'b0010, 0, "t5_no_watchdog");
`endif
        cyc(0, 4'b0000, 0, 4'b0000, 0, "t5_idle");

        cyc(1, 4'b0101, 0, 4'b0100, 0, "t2_grant");
        cyc(1, 4'b1101, 0, 4'b0100, 0, "t2_hold1");
        cyc(1, 4'b1101, 0, 4'b0100, 0, "t2_hold2");
        cyc(1, 4'b1101, 1, 4'b1000, 0, "t2_next");
        cyc(1, 4'b0000, 0, 4'b0000, 0, "t2_idle");

        cyc(0, 4'b0100, 0, 4'b0100, 0, "t6_grant");
        #2;
        rst_n = 1'b0;
        #1;
        expect_now(0, 4'b0000, 0, "t6_async_clear");
        chk();
        @(posedge clk);
        #1;
        expect_now(0, 4'b0000, 0, "t6_held_reset");
        chk();
        rst_n = 1'b1;
        cyc(0, 4'b1111, 0, 4'b0001, 0, "t6_ptr0");
        cyc(0, 4'b1111, 1, 4'b0010, 0, "t6_next");
        cyc(0, 4'b0000, 0, 4'b0000, 0, "t6_idle");

        checks++;
        assert (q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
